// File: rtl/obi_data_demux.sv
// Purpose: routes one OBI data port to NT address-decoded targets; unmapped accesses get an error response.
// Latency: zero added latency on request and on response; the error response comes one cycle after its grant.
// Backpressure: a request stalls while the outstanding count is at MAX_OUT, while a different target still owes
//   responses, or while an error response is pending. Ports: core side req/gnt/addr/we/be/wdata and
//   rvalid/rdata/err; per-target tgt_req/tgt_gnt/tgt_rvalid/tgt_rdata; broadcast addr/we/be/wdata;
//   status outstanding_o and sticky proto_err_o.
module obi_data_demux #(
    parameter int unsigned       NT       = 4,
    parameter logic [NT*32-1:0]  TGT_BASE = {32'h80000000, 32'h00110000, 32'h00140000, 32'h00001000},
    parameter logic [NT*32-1:0]  TGT_SIZE = {32'h00001000, 32'h00030000, 32'h00030000, 32'h000FF000},
    parameter int unsigned       MAX_OUT  = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    // core side
    input  logic             req_i,
    output logic             gnt_o,
    input  logic [31:0]      addr_i,
    input  logic             we_i,
    input  logic [3:0]       be_i,
    input  logic [31:0]      wdata_i,
    output logic             rvalid_o,
    output logic [31:0]      rdata_o,
    output logic             err_o,
    // target side
    output logic [NT-1:0]    tgt_req_o,
    output logic [31:0]      tgt_addr_o,
    output logic             tgt_we_o,
    output logic [3:0]       tgt_be_o,
    output logic [31:0]      tgt_wdata_o,
    input  logic [NT-1:0]    tgt_gnt_i,
    input  logic [NT-1:0]    tgt_rvalid_i,
    input  logic [NT*32-1:0] tgt_rdata_i,
    // status
    output logic [3:0]       outstanding_o,
    output logic             proto_err_o
);

    // Selector needs one extra code for the internal error sink (sel == NT).
    localparam int unsigned SELW = $clog2(NT + 1);
    localparam logic [SELW-1:0] SEL_ERR = SELW'(NT);

    logic [SELW-1:0] sel;
    logic [SELW-1:0] cur_tgt;
    logic [3:0]      cnt;
    logic            err_pend;
    logic            proto_err_q;

    logic            stall;
    logic            gnt_sel;
    logic            rv_cur;
    logic [31:0]     rdata_cur;
    logic            multi_rv;
    logic            good_rsp;
    logic            accept;
    logic            proto_set;
    logic [3:0]      cnt_nxt;

    // Address decode; walking from the top index down lets the lowest index win on overlap.
    always_comb begin
        sel = SEL_ERR;
        for (int k = NT - 1; k >= 0; k--) begin
            if ((addr_i >= TGT_BASE[k*32 +: 32]) &&
                ((addr_i - TGT_BASE[k*32 +: 32]) < TGT_SIZE[k*32 +: 32])) begin
                sel = SELW'(k);
            end
        end
    end

    // Per-index muxing written as loops so sel/cur_tgt == NT never indexes out of range.
    always_comb begin
        gnt_sel   = 1'b0;
        rv_cur    = 1'b0;
        rdata_cur = 32'h0;
        for (int k = 0; k < NT; k++) begin
            if (sel == SELW'(k)) begin
                gnt_sel = tgt_gnt_i[k];
            end
            if (cur_tgt == SELW'(k)) begin
                rv_cur    = tgt_rvalid_i[k];
                rdata_cur = tgt_rdata_i[k*32 +: 32];
            end
        end
    end

    // Stall uses only registered state and the decode, so tgt_rvalid_i never reaches gnt_o.
    always_comb begin
        stall = req_i & ((cnt == 4'(MAX_OUT)) ||
                         ((cnt != 4'd0) && (sel != cur_tgt)) ||
                         ((sel == SEL_ERR) && (cnt != 4'd0)) ||
                         err_pend);
    end

    // Reset also masks the combinational handshakes so every control output reads 0 during reset.
    always_comb begin
        tgt_req_o = '0;
        for (int k = 0; k < NT; k++) begin
            tgt_req_o[k] = rst_ni & req_i & ~stall & (sel == SELW'(k));
        end
        gnt_o = rst_ni & req_i & ~stall & ((sel == SEL_ERR) ? 1'b1 : gnt_sel);
    end

    assign tgt_addr_o  = addr_i;
    assign tgt_we_o    = we_i;
    assign tgt_be_o    = be_i;
    assign tgt_wdata_o = wdata_i;

    assign accept = req_i & gnt_o;

    // A target response is legal only from the owning target, with something outstanding to it,
    // and alone on the bus. Anything else is flagged and dropped.
    assign multi_rv  = ($countones(tgt_rvalid_i) > 1);
    assign good_rsp  = (cnt != 4'd0) & ~err_pend & rv_cur & ~multi_rv;
    assign proto_set = (|tgt_rvalid_i) & ~good_rsp;

    assign rvalid_o = err_pend | good_rsp;
    assign err_o    = err_pend;
    assign rdata_o  = good_rsp ? rdata_cur : 32'h0;

    always_comb begin
        cnt_nxt = cnt;
        case ({accept, rvalid_o})
            2'b10:   cnt_nxt = cnt + 4'd1;
            2'b01:   cnt_nxt = cnt - 4'd1;
            default: cnt_nxt = cnt;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt         <= 4'd0;
            cur_tgt     <= '0;
            err_pend    <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            // An error accept parks cur_tgt on the sink code so any stray target response is flagged.
            if (accept) begin
                cur_tgt <= sel;
            end
            // Stall holds off new accepts while err_pend is set, so it lives exactly one cycle.
            err_pend <= accept & (sel == SEL_ERR);
            if (proto_set) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    assign outstanding_o = cnt;
    assign proto_err_o   = proto_err_q;

endmodule
